// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: demand-driven NS/EW/pedestrian phase sequencer with tick-based timing.
// Optional night flashing mode is enabled by defining NIGHT_FLASH_EN (adds night_mode input and FLASH state).
module intersection_phase_scheduler #(
   parameter int unsigned GREEN_MIN  = 9,
   parameter int unsigned EW_GREEN_T = 6,
   parameter int unsigned YELLOW_T   = 3,
   parameter int unsigned ALLRED_T   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       car_sense_ew,
   input  logic       ped_req,
`ifdef NIGHT_FLASH_EN
   input  logic       night_mode,
`endif
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       ped_walk,
   output logic       ped_pending,
   output logic [3:0] remaining,
   output logic [2:0] phase
);
   localparam logic [3:0] D_GREEN = 4'(GREEN_MIN);
   localparam logic [3:0] D_EWG   = 4'(EW_GREEN_T);
   localparam logic [3:0] D_YEL   = 4'(YELLOW_T);
   localparam logic [3:0] D_AR    = 4'(ALLRED_T);
   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      ALLRED_A  = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
`ifdef NIGHT_FLASH_EN
      ALLRED_B  = 3'd5,
      FLASH     = 3'd6
`else
      ALLRED_B  = 3'd5
`endif
   } state_e;
   state_e     state_q, state_d, nxt;
   logic [3:0] rem_q, rem_d, nxt_dur, rem_dec;
   logic       ped_q, ped_d, expire;
`ifdef NIGHT_FLASH_EN
   logic       blink_q, blink_d;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= NS_GREEN;
         rem_q   <= D_GREEN;
         ped_q   <= 1'b0;
`ifdef NIGHT_FLASH_EN
         blink_q <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         ped_q   <= ped_d;
`ifdef NIGHT_FLASH_EN
         blink_q <= blink_d;
`endif
      end
   end
   // Fixed service order of the timed states and the duration each one loads on entry.
   always_comb begin
      nxt = state_q == NS_YELLOW ? ALLRED_A :
            state_q == ALLRED_A  ? EW_GREEN :
            state_q == EW_GREEN  ? EW_YELLOW :
            state_q == EW_YELLOW ? ALLRED_B : NS_GREEN;
      nxt_dur = (nxt == ALLRED_A || nxt == ALLRED_B) ? D_AR :
                nxt == EW_GREEN ? D_EWG :
                nxt == NS_GREEN ? D_GREEN : D_YEL;
      rem_dec = (tick && rem_q != 4'd0) ? rem_q - 4'd1 : rem_q;
      expire  = tick && rem_q == 4'd1;
   end
   always_comb begin
      state_d = state_q;
      rem_d   = rem_dec;
      case (state_q)
         NS_GREEN: begin
            if ((car_sense_ew || ped_q) && (expire || rem_q == 4'd0)) begin
               state_d = NS_YELLOW;
               rem_d   = D_YEL;
            end
`ifdef NIGHT_FLASH_EN
            if (night_mode && rem_q == 4'd0) begin
               state_d = FLASH;
               rem_d   = 4'd0;
            end
`endif
         end
`ifdef NIGHT_FLASH_EN
         FLASH: begin
            rem_d = 4'd0;
            if (!night_mode) begin
               state_d = ALLRED_B;
               rem_d   = D_AR;
            end
         end
`endif
         default: if (expire) begin
            state_d = nxt;
            rem_d   = nxt_dur;
         end
      endcase
   end
   // Entering EW_GREEN serves the walk, so the clear must beat a same-cycle press.
   assign ped_d = (state_d == EW_GREEN && state_q != EW_GREEN) ? 1'b0 :
                  (ped_req && state_q != EW_GREEN) ? 1'b1 : ped_q;
`ifdef NIGHT_FLASH_EN
   assign blink_d = state_q == FLASH ? blink_q ^ tick : 1'b1;
`endif
   always_comb begin
      ns_light = state_q == NS_GREEN ? 3'b100 : state_q == NS_YELLOW ? 3'b010 : 3'b001;
      ew_light = state_q == EW_GREEN ? 3'b100 : state_q == EW_YELLOW ? 3'b010 : 3'b001;
`ifdef NIGHT_FLASH_EN
      ns_light = state_q == FLASH ? {1'b0, blink_q, 1'b0} : ns_light;
      ew_light = state_q == FLASH ? {2'b00, blink_q} : ew_light;
`endif
   end
   assign ped_walk    = state_q == EW_GREEN;
   assign ped_pending = ped_q;
   assign remaining   = rem_q;
   assign phase       = state_q;
endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb_intersection_phase_scheduler: table-driven and hand-sequenced checks of the phase scheduler
// against a scoreboard of expected phase, countdown, pedestrian latch and light decode.
module tb_intersection_phase_scheduler;
   logic       clk = 1'b0;
   logic       rst, tick, car_sense_ew, ped_req;
   logic [2:0] ns_light, ew_light, phase;
   logic       ped_walk, ped_pending;
   logic [3:0] remaining;
`ifdef NIGHT_FLASH_EN
   logic       night_mode = 1'b0;
`endif
   int n_run = 0, n_fail = 0;
   typedef struct packed {
      logic       r, t, c, p;
      logic [2:0] ph;
      logic [3:0] rem;
      logic       pp;
      logic [2:0] ns, ew;
      logic       walk;
   } vec_t;
   vec_t tbl[$];
   vec_t sb[$];
   intersection_phase_scheduler dut (
      .clk(clk), .rst(rst), .tick(tick), .car_sense_ew(car_sense_ew), .ped_req(ped_req),
`ifdef NIGHT_FLASH_EN
      .night_mode(night_mode),
`endif
      .ns_light(ns_light), .ew_light(ew_light), .ped_walk(ped_walk),
      .ped_pending(ped_pending), .remaining(remaining), .phase(phase)
   );
   always #5 clk = ~clk;
   function automatic vec_t mk(logic r, logic t, logic c, logic p, logic [2:0] ph, logic [3:0] rem, logic pp);
      vec_t v;
      v = '0;
      {v.r, v.t, v.c, v.p, v.ph, v.rem, v.pp} = {r, t, c, p, ph, rem, pp};
      case (ph)
         3'd0:    {v.ns, v.ew, v.walk} = {3'b100, 3'b001, 1'b0};
         3'd1:    {v.ns, v.ew, v.walk} = {3'b010, 3'b001, 1'b0};
         3'd3:    {v.ns, v.ew, v.walk} = {3'b001, 3'b100, 1'b1};
         3'd4:    {v.ns, v.ew, v.walk} = {3'b001, 3'b010, 1'b0};
         default: {v.ns, v.ew, v.walk} = {3'b001, 3'b001, 1'b0};
      endcase
      return v;
   endfunction
   task automatic check(string name, logic [7:0] act, logic [7:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask
   task automatic step(vec_t v);
      vec_t e;
      rst = v.r; tick = v.t; car_sense_ew = v.c; ped_req = v.p;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("phase", {5'd0, phase}, {5'd0, e.ph});
      check("remaining", {4'd0, remaining}, {4'd0, e.rem});
      check("ped_pending", {7'd0, ped_pending}, {7'd0, e.pp});
      check("ns_light", {5'd0, ns_light}, {5'd0, e.ns});
      check("ew_light", {5'd0, ew_light}, {5'd0, e.ew});
      check("ped_walk", {7'd0, ped_walk}, {7'd0, e.walk});
   endtask
   // Full service cycle from NS_GREEN at 9 with the car waiting, one tick per step.
   function automatic void add_car_cycle();
      logic [2:0] ph [0:6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
      logic [3:0] d  [0:6] = '{4'd9, 4'd3, 4'd1, 4'd6, 4'd3, 4'd1, 4'd9};
      for (int s = 0; s < 6; s++) begin
         for (int j = int'(d[s]) - 1; j >= 1; j--) tbl.push_back(mk(0, 1, 1, 0, ph[s], 4'(j), 0));
         tbl.push_back(mk(0, 1, 1, 0, ph[s+1], d[s+1], 0));
      end
   endfunction
   initial begin
      rst = 1'b1; tick = 1'b0; car_sense_ew = 1'b0; ped_req = 1'b0;
      tbl.push_back(mk(1, 1, 0, 0, 3'd0, 4'd9, 0));
      for (int i = 1; i <= 20; i++) tbl.push_back(mk(0, 1, 0, 0, 3'd0, 4'(i > 9 ? 0 : 9 - i), 0));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 0, 3'd0, 4'd0, 0));
      tbl.push_back(mk(1, 0, 1, 0, 3'd0, 4'd9, 0));
      add_car_cycle();
      @(posedge clk);
      #1;
      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
      // Pedestrian pulse at rest: request latches, service starts on the next clock with no tick.
      step(mk(1, 0, 0, 0, 3'd0, 4'd9, 0));
      for (int i = 1; i <= 12; i++) step(mk(0, 1, 0, 0, 3'd0, 4'(i > 9 ? 0 : 9 - i), 0));
      step(mk(0, 0, 0, 1, 3'd0, 4'd0, 1));
      step(mk(0, 0, 0, 0, 3'd1, 4'd3, 1));
      step(mk(0, 1, 0, 0, 3'd1, 4'd2, 1));
      step(mk(0, 1, 0, 0, 3'd1, 4'd1, 1));
      step(mk(0, 1, 0, 0, 3'd2, 4'd1, 1));
      step(mk(0, 1, 0, 1, 3'd3, 4'd6, 0));
      // Button held through the walk: ignored in EW_GREEN, relatches in EW_YELLOW.
      for (int j = 5; j >= 1; j--) step(mk(0, 1, 0, 1, 3'd3, 4'(j), 0));
      step(mk(0, 1, 0, 1, 3'd4, 4'd3, 0));
      step(mk(0, 0, 0, 1, 3'd4, 4'd3, 1));
      step(mk(0, 1, 0, 0, 3'd4, 4'd2, 1));
      step(mk(0, 1, 0, 0, 3'd4, 4'd1, 1));
      step(mk(0, 1, 0, 0, 3'd5, 4'd1, 1));
      step(mk(0, 1, 0, 0, 3'd0, 4'd9, 1));
      for (int j = 8; j >= 1; j--) step(mk(0, 1, 0, 0, 3'd0, 4'(j), 1));
      step(mk(0, 1, 0, 0, 3'd1, 4'd3, 1));
      // Car leaves after yellow starts; cycle still completes, then reset mid walk with a tick.
      step(mk(1, 0, 0, 0, 3'd0, 4'd9, 0));
      for (int j = 8; j >= 1; j--) step(mk(0, 1, 1, 0, 3'd0, 4'(j), 0));
      step(mk(0, 1, 1, 0, 3'd1, 4'd3, 0));
      step(mk(0, 1, 0, 0, 3'd1, 4'd2, 0));
      step(mk(0, 1, 0, 0, 3'd1, 4'd1, 0));
      step(mk(0, 1, 0, 0, 3'd2, 4'd1, 0));
      step(mk(0, 1, 0, 0, 3'd3, 4'd6, 0));
      step(mk(0, 1, 0, 0, 3'd3, 4'd5, 0));
      step(mk(1, 1, 0, 1, 3'd0, 4'd9, 0));
      step(mk(0, 0, 0, 0, 3'd0, 4'd9, 0));
`ifdef NIGHT_FLASH_EN
      begin
         vec_t v;
         for (int j = 8; j >= 0; j--) step(mk(0, 1, 0, 0, 3'd0, 4'(j), 0));
         night_mode = 1'b1;
         v = mk(0, 0, 0, 0, 3'd6, 4'd0, 0); v.ns = 3'b010; v.ew = 3'b001; step(v);
         v = mk(0, 1, 0, 0, 3'd6, 4'd0, 0); v.ns = 3'b000; v.ew = 3'b000; step(v);
         v = mk(0, 1, 0, 0, 3'd6, 4'd0, 0); v.ns = 3'b010; v.ew = 3'b001; step(v);
         night_mode = 1'b0;
         step(mk(0, 0, 0, 0, 3'd5, 4'd1, 0));
         step(mk(0, 1, 0, 0, 3'd0, 4'd9, 0));
      end
`endif
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
- Sequences a two-road intersection: a main road (NS) and a side road (EW) with a pedestrian crossing over NS.
- Main road rests in green. The scheduler serves the side road and pedestrians only on demand: a vehicle sensor or a latched push-button.
- Timing is driven by an external 1 Hz `tick` enable pulse. `remaining` feeds the existing seven-segment display path.

Parameters:
- GREEN_MIN, 9, minimum NS green in ticks (1..15)
- EW_GREEN_T, 6, fixed EW green / NS walk duration in ticks (1..15)
- YELLOW_T, 3, yellow duration for either road in ticks (1..15)
- ALLRED_T, 1, all-red clearance in ticks (1..15)

Ports:
- clk, input, 1, system clock
- rst, input, 1, synchronous active-high reset
- tick, input, 1, one-cycle pulse per second; every cycle with tick=1 counts
- car_sense_ew, input, 1, level: vehicle waiting on EW
- ped_req, input, 1, pedestrian button to cross NS (pulse or level)
- ns_light, output, 3, {green, yellow, red}, one-hot
- ew_light, output, 3, {green, yellow, red}, one-hot
- ped_walk, output, 1, walk signal for crossing NS
- ped_pending, output, 1, latched pedestrian request
- remaining, output, 4, ticks left in current phase; 0 while NS rests
- phase, output, 3, state encoding for debug

Behaviour:
- Reset and clock: rst is synchronous, active-high, clock clk. rst has priority over all other inputs.
- Reset values: state=NS_GREEN, remaining=GREEN_MIN, ped_pending=0, ns_light=100, ew_light=001, ped_walk=0, phase=0.
- Output decode: lights, ped_walk and phase are a Moore decode of the state register, so they change on the same edge as the state.
- State encodings: NS_GREEN=0, NS_YELLOW=1, ALLRED_A=2, EW_GREEN=3, EW_YELLOW=4, ALLRED_B=5, FLASH=6 (FLASH only with the optional feature).
- Light decode:
  - NS_GREEN: ns=100, ew=001
  - NS_YELLOW: ns=010, ew=001
  - ALLRED_A and ALLRED_B: ns=001, ew=001
  - EW_GREEN: ns=001, ew=100, ped_walk=1
  - EW_YELLOW: ns=001, ew=010
  - ped_walk=0 in every other state.
- Timed states (all except NS_GREEN):
  - On entry, remaining is loaded with the state duration D.
  - Each tick decrements remaining.
  - A tick while remaining==1 advances the state on that edge and loads the next state's D. Each timed state therefore lasts exactly D ticks.
  - Sequence: NS_YELLOW(YELLOW_T) -> ALLRED_A(ALLRED_T) -> EW_GREEN(EW_GREEN_T) -> EW_YELLOW(YELLOW_T) -> ALLRED_B(ALLRED_T) -> NS_GREEN(GREEN_MIN).
- NS_GREEN:
  - Decrements on each tick down to 0, then holds at 0.
  - demand = car_sense_ew | ped_pending.
  - Leaves to NS_YELLOW on a tick with remaining==1 and demand=1, or on any clock edge where remaining==0 and demand=1 (no tick needed).
  - With no demand it stays indefinitely at remaining=0.
- ped_pending:
  - Set on any cycle where ped_req=1 and state is not EW_GREEN.
  - Cleared on the edge entering EW_GREEN; clear wins over a simultaneous set.
  - ped_req during EW_GREEN is ignored (walk is already active).
- Demand changes: demand dropping after NS_YELLOW has started has no effect; the cycle always completes.
- tick while rst=1 is ignored.
- Arithmetic: remaining is 4 bits with no wrap. It never decrements below 0.

Optional Feature:
- Macro: NIGHT_FLASH_EN.
- When defined, adds input `night_mode` (1 bit) and state FLASH.
- Entry: night_mode=1 is sampled only in NS_GREEN with remaining==0, and moves to FLASH on the next edge.
- In FLASH:
  - A blink register toggles on every tick, reset value 1.
  - ns_light = {1'b0, blink, 1'b0}; ew_light = {2'b00, blink}.
  - ped_walk=0; remaining=0.
  - ped_pending still latches requests.
- Exit: night_mode=0 leads to ALLRED_B, loaded with ALLRED_T, then the normal sequence.
- When not defined: no night_mode port, no FLASH state, and phase value 6 is unreachable.

Test Plan:
- Reset then 20 ticks with no demand: NS_GREEN held; remaining goes 9..0 and stays 0; ns_light=100, ew_light=001 throughout.
- car_sense_ew=1 from reset: NS_GREEN exactly 9 ticks, NS_YELLOW 3, ALLRED_A 1, EW_GREEN 6 with ped_walk=1, EW_YELLOW 3, ALLRED_B 1, then NS_GREEN with remaining=9.
- One-cycle ped_req pulse at tick 12 after reset, no car: ped_pending=1, NS_YELLOW entered on the next clock without waiting for a tick; ped_pending=0 on entry to EW_GREEN.
- ped_req held high across the whole EW_GREEN: ped_pending stays 0 during EW_GREEN, re-sets on the first cycle of EW_YELLOW, and triggers a second service after GREEN_MIN.
- rst asserted mid EW_GREEN with tick=1 on the same cycle: next cycle state=NS_GREEN, remaining=9, ped_pending=0, ped_walk=0.
- With NIGHT_FLASH_EN: night_mode=1 at rest gives FLASH; ns yellow and ew red toggle on each tick starting ON; night_mode=0 gives ALLRED_B for 1 tick, then NS_GREEN with remaining=9.
